main_control_fsm: RTL and testbench

// - Multi-cycle RISC-V control FSM. Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, jal, beq.
// - Loads the instruction register via o_IRWrite. That register's opcode field drives ImmDecoder (o_ImmSrc) and this block's i_OpCode.
// - o_ALUOp drives the ALU decoder. All other outputs drive the datapath muxes and write enables.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/main_control_fsm.sv | 163 ++++++++++++++++
 tb/tb_main_control_fsm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: opcodes (also used by ImmDecoder), control FSM states
// and the datapath mux select encodings driven by the control FSM.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LW     = 7'd3,
        OP_I_TYPE = 7'd19,
        OP_SW     = 7'd35,
        OP_R_TYPE = 7'd51,
        OP_BEQ    = 7'd99,
        OP_JAL    = 7'd111
    } OpCode_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } State_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle RISC-V main control FSM: sequences fetch/decode/execute/memory/
// writeback for lw, sw, R-type, I-type, jal and beq.
module main_control_fsm
    import riscv_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_OpCode,
    input  logic       i_Zero,
    input  logic       i_MemReady,
    output logic       o_PCWrite,
    output logic       o_AdrSrc,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp,
    output logic       o_Branch,
    output logic       o_InstrDone,
    output logic       o_IllegalOp
);

    State_t r_State;
    State_t w_NextState;
    logic   w_PCUpdate;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= S_FETCH;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = S_FETCH;
        case (r_State)
            S_FETCH:    w_NextState = i_MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_OpCode)
                    OP_LW, OP_SW: w_NextState = S_MEMADR;
                    OP_R_TYPE:    w_NextState = S_EXECR;
                    OP_I_TYPE:    w_NextState = S_EXECI;
                    OP_JAL:       w_NextState = S_JAL;
                    OP_BEQ:       w_NextState = S_BEQ;
                    default:      w_NextState = S_FETCH;
                endcase
            end
            S_MEMADR:   w_NextState = (i_OpCode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_NextState = i_MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_NextState = S_FETCH;
            S_MEMWRITE: w_NextState = i_MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_NextState = S_ALUWB;
            S_EXECI:    w_NextState = S_ALUWB;
            S_JAL:      w_NextState = S_ALUWB;
            S_ALUWB:    w_NextState = S_FETCH;
            S_BEQ:      w_NextState = S_FETCH;
            default:    w_NextState = S_FETCH;
        endcase
        if (i_Reset) begin
            w_NextState = S_FETCH;
        end
    end

    always_comb begin
        o_AdrSrc    = 1'b0;
        o_MemWrite  = 1'b0;
        o_IRWrite   = 1'b0;
        o_RegWrite  = 1'b0;
        o_ResultSrc = RES_ALUOUT;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_RS2;
        o_ALUOp     = ALUOP_ADD;
        o_Branch    = 1'b0;
        o_InstrDone = 1'b0;
        o_IllegalOp = 1'b0;
        w_PCUpdate  = 1'b0;
        case (r_State)
            S_FETCH: begin
                // PC+4 is written back directly from the ALU result while the
                // fetch completes, so IR and PC only update once memory is ready.
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALURESULT;
                o_IRWrite   = i_MemReady;
                w_PCUpdate  = i_MemReady;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                case (i_OpCode)
                    OP_LW, OP_SW, OP_R_TYPE, OP_I_TYPE, OP_JAL, OP_BEQ: ;
                    default: begin
                        o_IllegalOp = 1'b1;
                        o_InstrDone = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: o_AdrSrc = 1'b1;
            S_MEMWB: begin
                o_ResultSrc = RES_DATA;
                o_RegWrite  = 1'b1;
                o_InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                o_AdrSrc    = 1'b1;
                o_MemWrite  = 1'b1;
                o_InstrDone = i_MemReady;
            end
            S_EXECR: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_RS2;
                o_ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_IMM;
                o_ALUOp   = ALUOP_FUNCT;
            end
            S_JAL: begin
                o_ALUSrcA  = SRCA_OLDPC;
                o_ALUSrcB  = SRCB_FOUR;
                w_PCUpdate = 1'b1;
            end
            S_ALUWB: begin
                o_RegWrite  = 1'b1;
                o_InstrDone = 1'b1;
            end
            S_BEQ: begin
                o_ALUSrcA   = SRCA_RS1;
                o_ALUSrcB   = SRCB_RS2;
                o_ALUOp     = ALUOP_SUB;
                o_Branch    = 1'b1;
                o_InstrDone = 1'b1;
            end
            default: ;
        endcase
        // Reset silences every strobe in the same cycle so an aborted
        // instruction never commits a register, memory or PC write.
        if (i_Reset) begin
            o_AdrSrc    = 1'b0;
            o_MemWrite  = 1'b0;
            o_IRWrite   = 1'b0;
            o_RegWrite  = 1'b0;
            o_ResultSrc = 2'b00;
            o_ALUSrcA   = 2'b00;
            o_ALUSrcB   = 2'b00;
            o_ALUOp     = 2'b00;
            o_Branch    = 1'b0;
            o_InstrDone = 1'b0;
            o_IllegalOp = 1'b0;
            w_PCUpdate  = 1'b0;
        end
    end

    assign o_PCWrite = (o_Branch & i_Zero) | w_PCUpdate;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: a per-instruction reference model
// expands each instruction into its expected per-cycle control vectors.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       i_Reset;
    logic [6:0] i_OpCode;
    logic       i_Zero;
    logic       i_MemReady;
    logic       o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite;
    logic [1:0] o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp;
    logic       o_Branch, o_InstrDone, o_IllegalOp;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .i_Clk       (clk),
        .i_Reset     (i_Reset),
        .i_OpCode    (i_OpCode),
        .i_Zero      (i_Zero),
        .i_MemReady  (i_MemReady),
        .o_PCWrite   (o_PCWrite),
        .o_AdrSrc    (o_AdrSrc),
        .o_MemWrite  (o_MemWrite),
        .o_IRWrite   (o_IRWrite),
        .o_RegWrite  (o_RegWrite),
        .o_ResultSrc (o_ResultSrc),
        .o_ALUSrcA   (o_ALUSrcA),
        .o_ALUSrcB   (o_ALUSrcB),
        .o_ALUOp     (o_ALUOp),
        .o_Branch    (o_Branch),
        .o_InstrDone (o_InstrDone),
        .o_IllegalOp (o_IllegalOp)
    );

    // Vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    //                 ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0],
    //                 Branch, InstrDone, IllegalOp}
    logic [15:0] w_obs;
    assign w_obs = {o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
                    o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
                    o_Branch, o_InstrDone, o_IllegalOp};

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    // Program buffer for one instruction (inputs to drive + expected outputs)
    logic [6:0]  p_op[$];
    logic        p_z[$];
    logic        p_rdy[$];
    logic        p_rst[$];
    logic [15:0] p_exp[$];
    string       p_name[$];

    logic [15:0] m_exp;
    string       m_name;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (t=%0t)", m_name, w_obs, m_exp, $time);
            end
        end
    end

    function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic br,
                                       input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, op, br, done, ill};
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] opc);
        return (opc == 7'd3) || (opc == 7'd35) || (opc == 7'd51) ||
               (opc == 7'd19) || (opc == 7'd111) || (opc == 7'd99);
    endfunction

    task automatic add(input string nm, input logic [6:0] op, input logic z,
                       input logic rdy, input logic rst, input logic [15:0] e);
        p_name.push_back(nm);
        p_op.push_back(op);
        p_z.push_back(z);
        p_rdy.push_back(rdy);
        p_rst.push_back(rst);
        p_exp.push_back(e);
    endtask

    // Reference model: expand one instruction into its cycle-by-cycle control vectors.
    // Opcode is only meaningful in decode/memadr, so other cycles drive noise on it.
    task automatic build(input logic [6:0] opc, input int fw, input int mw, input logic z);
        logic legal;
        legal = is_legal(opc);
        for (int i = 0; i < fw; i++)
            add("fetch_wait", rnd_op(), rnd_bit(), 1'b0, 1'b0,
                mk(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0,0));
        add("fetch", rnd_op(), rnd_bit(), 1'b1, 1'b0,
            mk(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0,0));
        add(legal ? "decode" : "decode_illegal", opc, rnd_bit(), rnd_bit(), 1'b0,
            mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0, !legal, !legal));
        case (opc)
            7'd3: begin
                add("lw_memadr", opc, rnd_bit(), rnd_bit(), 1'b0,
                    mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0,0));
                for (int i = 0; i < mw; i++)
                    add("lw_memread_wait", rnd_op(), rnd_bit(), 1'b0, 1'b0,
                        mk(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0,0));
                add("lw_memread", rnd_op(), rnd_bit(), 1'b1, 1'b0,
                    mk(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0,0));
                add("lw_memwb", rnd_op(), rnd_bit(), rnd_bit(), 1'b0,
                    mk(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 0,1,0));
            end
            7'd35: begin
                add("sw_memadr", opc, rnd_bit(), rnd_bit(), 1'b0,
                    mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0,0));
                for (int i = 0; i < mw; i++)
                    add("sw_memwrite_wait", rnd_op(), rnd_bit(), 1'b0, 1'b0,
                        mk(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0,0));
                add("sw_memwrite", rnd_op(), rnd_bit(), 1'b1, 1'b0,
                    mk(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1,0));
            end
            7'd51, 7'd19, 7'd111: begin
                if (opc == 7'd51)
                    add("execr", rnd_op(), rnd_bit(), rnd_bit(), 1'b0,
                        mk(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0,0));
                else if (opc == 7'd19)
                    add("execi", rnd_op(), rnd_bit(), rnd_bit(), 1'b0,
                        mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 0,0,0));
                else
                    add("jal", rnd_op(), rnd_bit(), rnd_bit(), 1'b0,
                        mk(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0,0,0));
                add("aluwb", rnd_op(), rnd_bit(), rnd_bit(), 1'b0,
                    mk(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0,1,0));
            end
            7'd99: begin
                add(z ? "beq_taken" : "beq_not_taken", rnd_op(), z, rnd_bit(), 1'b0,
                    mk(z,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 1,1,0));
            end
            default: ;
        endcase
    endtask

    task automatic run_prog();
        for (int i = 0; i < p_op.size(); i++) begin
            i_Reset    = p_rst[i];
            i_OpCode   = p_op[i];
            i_Zero     = p_z[i];
            i_MemReady = p_rdy[i];
            exp_q.push_back(p_exp[i]);
            name_q.push_back(p_name[i]);
            @(posedge clk);
            #1;
        end
        p_op.delete(); p_z.delete(); p_rdy.delete();
        p_rst.delete(); p_exp.delete(); p_name.delete();
    endtask

    // abort_at < 0 (or past the end) runs the instruction to completion;
    // otherwise reset replaces the cycle at that index.
    task automatic do_instr(input logic [6:0] opc, input int fw, input int mw,
                            input logic z, input int abort_at);
        build(opc, fw, mw, z);
        if (abort_at >= 0 && abort_at < p_op.size()) begin
            while (p_op.size() > abort_at) begin
                void'(p_op.pop_back()); void'(p_z.pop_back()); void'(p_rdy.pop_back());
                void'(p_rst.pop_back()); void'(p_exp.pop_back()); void'(p_name.pop_back());
            end
            add("reset_abort", rnd_op(), rnd_bit(), rnd_bit(), 1'b1, 16'h0000);
        end
        run_prog();
    endtask

    initial begin
        logic [6:0] opc;
        int         kind;
        i_Reset    = 1'b1;
        i_OpCode   = 7'd51;
        i_Zero     = 1'b0;
        i_MemReady = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            add("reset_hold", 7'd51, 1'b1, 1'b1, 1'b1, 16'h0000);
        run_prog();

        do_instr(7'd3,   0, 0, 1'b0, -1);
        do_instr(7'd35,  0, 2, 1'b0, -1);
        do_instr(7'd99,  0, 0, 1'b1, -1);
        do_instr(7'd99,  0, 0, 1'b0, -1);
        do_instr(7'd111, 0, 0, 1'b0, -1);
        do_instr(7'd51,  0, 0, 1'b0, -1);
        do_instr(7'd19,  0, 0, 1'b0, -1);
        do_instr(7'h7F,  0, 0, 1'b0, -1);
        do_instr(7'd51,  0, 0, 1'b0, 2);
        do_instr(7'd3,   1, 2, 1'b0, -1);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: opc = 7'd3;
                1: opc = 7'd35;
                2: opc = 7'd51;
                3: opc = 7'd19;
                4: opc = 7'd111;
                5: opc = 7'd99;
                default: begin
                    opc = rnd_op();
                    while (is_legal(opc)) opc = rnd_op();
                end
            endcase
            do_instr(opc, $urandom_range(0, 2), $urandom_range(0, 2), rnd_bit(),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
